status_reg: RTL and testbench

//  6502 processor status (P) register and interrupt-poll unit; the consumer side of the ALU flag interface.

---
 rtl/status_reg.sv | 153 +++++++++++++++
 tb/tb_status_reg.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/status_reg.sv
// 6502 processor status register with flag update priority, branch decode and
// interrupt polling (IRQ/NMI synchronisers, NMI edge latch, boundary IRQ sampling).
module status_reg #(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter logic [7:0]  RESET_P      = 8'h04,
  parameter bit          INT_CLEARS_D = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       alu_n,
  input  logic       alu_v,
  input  logic       alu_z,
  input  logic       alu_c,
  input  logic       upd_nz,
  input  logic       upd_v,
  input  logic       upd_c,
  input  logic [2:0] flag_op,
  input  logic       plp,
  input  logic [7:0] db_in,
  input  logic       int_entry,
  input  logic       push_brk,
  input  logic [2:0] br_sel,
  input  logic       sync,
  input  logic       nmi_ack,
  input  logic       irq_n,
  input  logic       nmi_n,
  output logic [7:0] p_out,
  output logic       c_out,
  output logic       d_out,
  output logic       i_out,
  output logic       branch_taken,
  output logic       irq_pending,
  output logic       nmi_pending
);

  localparam logic [2:0] OP_CLC = 3'd1;
  localparam logic [2:0] OP_SEC = 3'd2;
  localparam logic [2:0] OP_CLI = 3'd3;
  localparam logic [2:0] OP_SEI = 3'd4;
  localparam logic [2:0] OP_CLD = 3'd5;
  localparam logic [2:0] OP_SED = 3'd6;
  localparam logic [2:0] OP_CLV = 3'd7;

  logic n_q, v_q, d_q, i_q, z_q, c_q;
  logic n_nx, v_nx, d_nx, i_nx, z_nx, c_nx;

  logic [SYNC_STAGES-1:0] irq_sync;
  logic [SYNC_STAGES-1:0] nmi_sync;
  logic                   irq_s, nmi_s, nmi_prev;

  // Next flag values: written lowest priority first so later writers override.
  always_comb begin
    n_nx = n_q;
    v_nx = v_q;
    d_nx = d_q;
    i_nx = i_q;
    z_nx = z_q;
    c_nx = c_q;
    if (upd_nz) begin
      n_nx = alu_n;
      z_nx = alu_z;
    end
    if (upd_v) v_nx = alu_v;
    if (upd_c) c_nx = alu_c;
    case (flag_op)
      OP_CLC:  c_nx = 1'b0;
      OP_SEC:  c_nx = 1'b1;
      OP_CLI:  i_nx = 1'b0;
      OP_SEI:  i_nx = 1'b1;
      OP_CLD:  d_nx = 1'b0;
      OP_SED:  d_nx = 1'b1;
      OP_CLV:  v_nx = 1'b0;
      default: ;
    endcase
    if (int_entry) begin
      i_nx = 1'b1;
      if (INT_CLEARS_D) d_nx = 1'b0;
    end
    if (plp) begin
      n_nx = db_in[7];
      v_nx = db_in[6];
      d_nx = db_in[3];
      i_nx = db_in[2];
      z_nx = db_in[1];
      c_nx = db_in[0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_q <= RESET_P[7];
      v_q <= RESET_P[6];
      d_q <= RESET_P[3];
      i_q <= RESET_P[2];
      z_q <= RESET_P[1];
      c_q <= RESET_P[0];
    end else begin
      n_q <= n_nx;
      v_q <= v_nx;
      d_q <= d_nx;
      i_q <= i_nx;
      z_q <= z_nx;
      c_q <= c_nx;
    end
  end

  // Synchronisers idle high (lines inactive) out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_sync <= '1;
      nmi_sync <= '1;
      nmi_prev <= 1'b1;
    end else begin
      irq_sync <= {irq_sync[SYNC_STAGES-2:0], irq_n};
      nmi_sync <= {nmi_sync[SYNC_STAGES-2:0], nmi_n};
      nmi_prev <= nmi_s;
    end
  end

  assign irq_s = irq_sync[SYNC_STAGES-1];
  assign nmi_s = nmi_sync[SYNC_STAGES-1];

  // IRQ sampled at instruction boundaries with the pre-write I flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_pending <= 1'b0;
      nmi_pending <= 1'b0;
    end else begin
      if (int_entry)  irq_pending <= 1'b0;
      else if (sync)  irq_pending <= ~irq_s & ~i_q;
      if (nmi_prev && !nmi_s) nmi_pending <= 1'b1;
      else if (nmi_ack)       nmi_pending <= 1'b0;
    end
  end

  assign p_out = {n_q, v_q, 1'b1, push_brk, d_q, i_q, z_q, c_q};
  assign c_out = c_q;
  assign d_out = d_q;
  assign i_out = i_q;

  // Branch flag select: 0 N, 1 V, 2 C, 3 Z.
  always_comb begin
    branch_taken = 1'b0;
    case (br_sel[2:1])
      2'd0: branch_taken = (n_q == br_sel[0]);
      2'd1: branch_taken = (v_q == br_sel[0]);
      2'd2: branch_taken = (c_q == br_sel[0]);
      2'd3: branch_taken = (z_q == br_sel[0]);
      default: ;
    endcase
  end

endmodule

// File: tb/tb_status_reg.sv
// Bench for status_reg: directed 6502 scenarios plus randomized traffic against
// a byte-level status/interrupt model.
module tb_status_reg;

  localparam int unsigned SYNC_STAGES  = 2;
  localparam logic [7:0]  RESET_P      = 8'h04;
  localparam bit          INT_CLEARS_D = 1'b0;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       alu_n, alu_v, alu_z, alu_c;
  logic       upd_nz, upd_v, upd_c;
  logic [2:0] flag_op;
  logic       plp;
  logic [7:0] db_in;
  logic       int_entry, push_brk;
  logic [2:0] br_sel;
  logic       sync, nmi_ack, irq_n, nmi_n;
  logic [7:0] p_out;
  logic       c_out, d_out, i_out, branch_taken, irq_pending, nmi_pending;

  int total = 0;
  int bad   = 0;

  // Model state: P byte with bits 5:4 held at zero, line history queues.
  logic [7:0] mp;
  bit         m_irq, m_nmi, m_nprev;
  bit         iq[$];
  bit         nq[$];

  int unsigned op_bit[8] = '{0, 0, 0, 2, 2, 3, 3, 6};
  bit          op_val[8] = '{0, 0, 1, 0, 1, 0, 1, 0};

  status_reg #(
    .SYNC_STAGES(SYNC_STAGES), .RESET_P(RESET_P), .INT_CLEARS_D(INT_CLEARS_D)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_n(alu_n), .alu_v(alu_v), .alu_z(alu_z), .alu_c(alu_c),
    .upd_nz(upd_nz), .upd_v(upd_v), .upd_c(upd_c),
    .flag_op(flag_op), .plp(plp), .db_in(db_in),
    .int_entry(int_entry), .push_brk(push_brk), .br_sel(br_sel),
    .sync(sync), .nmi_ack(nmi_ack), .irq_n(irq_n), .nmi_n(nmi_n),
    .p_out(p_out), .c_out(c_out), .d_out(d_out), .i_out(i_out),
    .branch_taken(branch_taken), .irq_pending(irq_pending), .nmi_pending(nmi_pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mp = RESET_P & 8'hCF;
    m_irq = 1'b0;
    m_nmi = 1'b0;
    m_nprev = 1'b1;
    iq = {};
    nq = {};
    repeat (SYNC_STAGES) begin
      iq.push_back(1'b1);
      nq.push_back(1'b1);
    end
  endtask

  // One clock edge of the reference: everything is computed from pre-edge values.
  task automatic model_step();
    logic [7:0] np;
    bit irq_s_old, nmi_s_old;
    irq_s_old = iq[0];
    nmi_s_old = nq[0];
    np = mp;
    if (upd_nz) begin np[7] = alu_n; np[1] = alu_z; end
    if (upd_v) np[6] = alu_v;
    if (upd_c) np[0] = alu_c;
    if (flag_op != 3'd0) np[op_bit[flag_op]] = op_val[flag_op];
    if (int_entry) begin
      np[2] = 1'b1;
      if (INT_CLEARS_D) np[3] = 1'b0;
    end
    if (plp) np = db_in & 8'hCF;
    if (int_entry) m_irq = 1'b0;
    else if (sync) m_irq = !irq_s_old && !mp[2];
    if (m_nprev && !nmi_s_old) m_nmi = 1'b1;
    else if (nmi_ack) m_nmi = 1'b0;
    m_nprev = nmi_s_old;
    void'(iq.pop_front());
    void'(nq.pop_front());
    iq.push_back(irq_n);
    nq.push_back(nmi_n);
    mp = np;
  endtask

  function automatic bit model_branch(input logic [2:0] sel);
    int unsigned idx[4] = '{7, 6, 0, 1};
    return mp[idx[sel[2:1]]] == sel[0];
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".p"},   p_out, mp | 8'h20 | {3'b000, push_brk, 4'b0000});
    check({tag, ".c"},   8'(c_out), 8'(mp[0]));
    check({tag, ".d"},   8'(d_out), 8'(mp[3]));
    check({tag, ".i"},   8'(i_out), 8'(mp[2]));
    check({tag, ".br"},  8'(branch_taken), 8'(model_branch(br_sel)));
    check({tag, ".irq"}, 8'(irq_pending), 8'(m_irq));
    check({tag, ".nmi"}, 8'(nmi_pending), 8'(m_nmi));
  endtask

  task automatic idle();
    {alu_n, alu_v, alu_z, alu_c} = 4'b0;
    {upd_nz, upd_v, upd_c} = 3'b0;
    flag_op = 3'd0;
    plp = 1'b0;
    db_in = 8'h00;
    int_entry = 1'b0;
    push_brk = 1'b0;
    br_sel = 3'd0;
    sync = 1'b0;
    nmi_ack = 1'b0;
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all(tag);
  endtask

  initial begin
    idle();
    irq_n = 1'b1;
    nmi_n = 1'b1;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst.p", p_out, 8'h24);
    check("rst.i", 8'(i_out), 8'h01);
    check("rst.c", 8'(c_out), 8'h00);
    check("rst.d", 8'(d_out), 8'h00);
    check("rst.pend", 8'({irq_pending, nmi_pending}), 8'h00);
    rst_n = 1'b1;

    // ALU update then CLC
    alu_c = 1'b1; alu_z = 1'b1; upd_c = 1'b1; upd_nz = 1'b1;
    step("alu");
    check("alu.lit", p_out, 8'h27);
    idle(); flag_op = 3'd1;
    step("clc");
    check("clc.lit", p_out, 8'h26);

    // PLP beats same-cycle upd_c
    idle(); db_in = 8'hFF; plp = 1'b1; upd_c = 1'b1; alu_c = 1'b0;
    step("plp");
    check("plp.lit0", p_out, 8'hEF);
    check("plp.c", 8'(c_out), 8'h01);
    idle(); push_brk = 1'b1; #1;
    check("plp.lit1", p_out, 8'hFF);

    // Branches with Z=1, C=0
    idle(); db_in = 8'h02; plp = 1'b1;
    step("setzc");
    br_sel = 3'b111; #1;
    check("beq", 8'(branch_taken), 8'h01);
    br_sel = 3'b101; #1;
    check("bcs", 8'(branch_taken), 8'h00);

    // CLI on a sync cycle polls with the old I; next sync sees the IRQ
    idle(); flag_op = 3'd4;
    step("sei");
    idle(); irq_n = 1'b0;
    repeat (3) step("irqlow");
    flag_op = 3'd3; sync = 1'b1;
    step("cli_sync");
    check("cli.irq0", 8'(irq_pending), 8'h00);
    idle(); sync = 1'b1;
    step("sync2");
    check("cli.irq1", 8'(irq_pending), 8'h01);
    idle(); int_entry = 1'b1;
    step("inte");
    check("inte.irq", 8'(irq_pending), 8'h00);
    check("inte.i", 8'(i_out), 8'h01);
    idle(); irq_n = 1'b1;

    // NMI: edge latency, ack while low, re-arm on new edge
    nmi_n = 1'b0;
    for (int k = 1; k <= SYNC_STAGES + 1; k++) begin
      step("nmi_fall");
      check("nmi.lat", 8'(nmi_pending), 8'(k == SYNC_STAGES + 1));
    end
    nmi_ack = 1'b1;
    step("nmi_ack");
    nmi_ack = 1'b0;
    for (int k = 0; k < 16; k++) step("nmi_hold");
    check("nmi.held", 8'(nmi_pending), 8'h00);
    nmi_n = 1'b1;
    repeat (4) step("nmi_hi");
    nmi_n = 1'b0;
    repeat (SYNC_STAGES + 1) step("nmi_fall2");
    check("nmi.rearm", 8'(nmi_pending), 8'h01);
    nmi_ack = 1'b1;
    step("nmi_ack2");

    // Randomized traffic, with an asynchronous reset in the middle
    for (int cyc = 0; cyc < 800; cyc++) begin
      alu_n = 1'($urandom); alu_v = 1'($urandom);
      alu_z = 1'($urandom); alu_c = 1'($urandom);
      upd_nz = ($urandom % 3 == 0);
      upd_v  = ($urandom % 4 == 0);
      upd_c  = ($urandom % 3 == 0);
      flag_op = ($urandom % 3 == 0) ? 3'($urandom) : 3'd0;
      plp = ($urandom % 12 == 0);
      db_in = 8'($urandom);
      int_entry = ($urandom % 16 == 0);
      sync = !int_entry && ($urandom % 4 == 0);
      nmi_ack = ($urandom % 6 == 0);
      push_brk = 1'($urandom);
      br_sel = 3'($urandom);
      if ($urandom % 8 == 0) irq_n = ~irq_n;
      if ($urandom % 10 == 0) nmi_n = ~nmi_n;
      if (cyc == 400) begin
        plp = 1'b1;
        db_in = 8'hCB;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("midrst");
        @(negedge clk);
        check_all("midrst_held");
        rst_n = 1'b1;
      end else begin
        step("rnd");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
